// File: rtl/password_pkg.sv
// Shared key codes, FSM state type and digit-buffer helpers for password_entry.
package password_pkg;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_BACK  = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_SHOW  = 4'hD;
    localparam logic [3:0] KEY_CHPW  = 4'hE;

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_UNLOCKED,
        ST_SETPW,
        ST_LOCKOUT
    } fsm_t;

    typedef logic [3:0][3:0] digit_buf_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } key_req_t;

    function automatic logic is_digit(input logic [3:0] c);
        return c <= 4'd9;
    endfunction

    // The first typed digit is the most significant nibble, so 1,2,3,4 reads as 16'h1234.
    function automatic logic [15:0] buf_to_code(input digit_buf_t b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

endpackage

// File: rtl/password_entry_lockout_timer.sv
// Lockout duration counter: runs while start is held, done marks the final cycle.
module lockout_timer #(
    parameter int unsigned LOCK_CYCLES = 250_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic done
);

    localparam logic [31:0] LAST = (LOCK_CYCLES == 0) ? 32'd0 : 32'(LOCK_CYCLES - 1);

    logic [31:0] cnt;

    // start is held high for the whole lockout; dropping it rearms the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!start) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + 32'd1;
        end
    end

    assign done = start && (cnt >= LAST);

endmodule

// File: rtl/password_entry.sv
// Four-digit keypad lock with lockout after repeated failures.
// Define PW_CHANGE_EN to allow changing the password from the unlocked state (key E).
module password_entry
    import password_pkg::*;
#(
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCK_CYCLES = 250_000_000,
    parameter logic [15:0] DEFAULT_PW  = 16'h1234
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [3:0] p0,
    output logic [3:0] p1,
    output logic [3:0] p2,
    output logic [3:0] p3,
    output logic [3:0] digit_valid,
    output logic       state,
    output logic       unlocked,
    output logic       alarm,
    output logic [3:0] fail_cnt
);

    localparam logic [3:0] FAIL_LIM = 4'(MAX_FAIL);

    fsm_t       fsm;
    digit_buf_t dbuf;
    logic [2:0] count;
    logic [15:0] pw;
    logic       lock_run;
    logic       lock_done;
    key_req_t   key;

    assign key      = '{valid: key_valid, code: key_code};
    assign lock_run = (fsm == ST_LOCKOUT);

`ifndef PW_CHANGE_EN
    assign pw = DEFAULT_PW;
`endif

    lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (lock_run),
        .done  (lock_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= ST_ENTRY;
            dbuf        <= '0;
            count       <= '0;
            digit_valid <= '0;
            state       <= 1'b0;
            unlocked    <= 1'b0;
            alarm       <= 1'b0;
            fail_cnt    <= '0;
`ifdef PW_CHANGE_EN
            pw          <= DEFAULT_PW;
`endif
        end else begin
            case (fsm)
                ST_ENTRY, ST_SETPW: begin
                    if (key.valid) begin
                        if (is_digit(key.code)) begin
                            if (count != 3'd4) begin
                                dbuf[count[1:0]]        <= key.code;
                                digit_valid[count[1:0]] <= 1'b1;
                                count                   <= count + 3'd1;
                            end
                        end else begin
                            case (key.code)
                                KEY_BACK: begin
                                    if (count != 3'd0) begin
                                        count <= count - 3'd1;
                                        digit_valid[2'(count - 3'd1)] <= 1'b0;
                                    end
                                end
                                KEY_CLEAR: begin
                                    count       <= '0;
                                    dbuf        <= '0;
                                    digit_valid <= '0;
                                    if (fsm == ST_SETPW) fsm <= ST_UNLOCKED;
                                end
                                KEY_ENTER: begin
                                    if (count == 3'd4) begin
                                        count       <= '0;
                                        dbuf        <= '0;
                                        digit_valid <= '0;
                                        if (fsm == ST_ENTRY) begin
                                            if (buf_to_code(dbuf) == pw) begin
                                                fsm      <= ST_UNLOCKED;
                                                unlocked <= 1'b1;
                                                fail_cnt <= '0;
                                            end else begin
                                                fail_cnt <= fail_cnt + 4'd1;
                                                if (fail_cnt + 4'd1 == FAIL_LIM) begin
                                                    fsm   <= ST_LOCKOUT;
                                                    alarm <= 1'b1;
                                                end
                                            end
                                        end else begin
`ifdef PW_CHANGE_EN
                                            pw  <= buf_to_code(dbuf);
`endif
                                            fsm <= ST_UNLOCKED;
                                        end
                                    end
                                end
                                KEY_SHOW: state <= ~state;
                                default: ;
                            endcase
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (key.valid) begin
                        case (key.code)
                            KEY_CLEAR: begin
                                fsm         <= ST_ENTRY;
                                unlocked    <= 1'b0;
                                count       <= '0;
                                dbuf        <= '0;
                                digit_valid <= '0;
                            end
                            KEY_SHOW: state <= ~state;
`ifdef PW_CHANGE_EN
                            KEY_CHPW: begin
                                fsm         <= ST_SETPW;
                                count       <= '0;
                                dbuf        <= '0;
                                digit_valid <= '0;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                ST_LOCKOUT: begin
                    // Keys are dropped here, including one arriving on the exit cycle.
                    if (lock_done) begin
                        fsm      <= ST_ENTRY;
                        alarm    <= 1'b0;
                        fail_cnt <= '0;
                    end
                end
                default: fsm <= ST_ENTRY;
            endcase
        end
    end

    assign p0 = dbuf[0];
    assign p1 = dbuf[1];
    assign p2 = dbuf[2];
    assign p3 = dbuf[3];

endmodule

// File: tb/tb_password_entry.sv
// Directed bench for password_entry: vector table plus lockout/reset/password-change sequences.
module tb_password_entry;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] p0, p1, p2, p3, digit_valid, fail_cnt;
    logic       state, unlocked, alarm;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    password_entry #(.MAX_FAIL(3), .LOCK_CYCLES(100), .DEFAULT_PW(16'h1234)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3), .digit_valid(digit_valid),
        .state(state), .unlocked(unlocked), .alarm(alarm), .fail_cnt(fail_cnt)
    );

    typedef struct {
        logic [3:0]  key;
        logic [15:0] p;     // {p0,p1,p2,p3}
        logic [3:0]  dv;
        logic        st;
        logic        unl;
        logic        alm;
        logic [3:0]  fc;
    } vec_t;

    vec_t vt[36];

    function automatic logic [26:0] obs();
        return {p0, p1, p2, p3, digit_valid, state, unlocked, alarm, fail_cnt};
    endfunction

    function automatic logic [26:0] mk(logic [15:0] p, logic [3:0] dv, logic st, logic unl,
                                       logic alm, logic [3:0] fc);
        return {p, dv, st, unl, alm, fc};
    endfunction

    task automatic chk(input string name, input logic [26:0] want);
        logic [26:0] got;
        got = obs();
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got p=%h dv=%b st=%b unl=%b alm=%b fc=%0d, want p=%h dv=%b st=%b unl=%b alm=%b fc=%0d",
                     name, got[26:11], got[10:7], got[6], got[5], got[4], got[3:0],
                     want[26:11], want[10:7], want[6], want[5], want[4], want[3:0]);
        end
    endtask

    task automatic apply(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic idle();
        key_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic code(input logic [3:0] a, b, c, d);
        apply(a); apply(b); apply(c); apply(d); apply(4'hA);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        vt[0]  = '{4'h1, 16'h1000, 4'b0001, 0, 0, 0, 4'd0};
        vt[1]  = '{4'h2, 16'h1200, 4'b0011, 0, 0, 0, 4'd0};
        vt[2]  = '{4'h3, 16'h1230, 4'b0111, 0, 0, 0, 4'd0};
        vt[3]  = '{4'h4, 16'h1234, 4'b1111, 0, 0, 0, 4'd0};
        vt[4]  = '{4'hA, 16'h0000, 4'b0000, 0, 1, 0, 4'd0};
        vt[5]  = '{4'hC, 16'h0000, 4'b0000, 0, 0, 0, 4'd0};
        vt[6]  = '{4'h1, 16'h1000, 4'b0001, 0, 0, 0, 4'd0};
        vt[7]  = '{4'h2, 16'h1200, 4'b0011, 0, 0, 0, 4'd0};
        vt[8]  = '{4'h5, 16'h1250, 4'b0111, 0, 0, 0, 4'd0};
        vt[9]  = '{4'hB, 16'h1250, 4'b0011, 0, 0, 0, 4'd0};
        vt[10] = '{4'h3, 16'h1230, 4'b0111, 0, 0, 0, 4'd0};
        vt[11] = '{4'h4, 16'h1234, 4'b1111, 0, 0, 0, 4'd0};
        vt[12] = '{4'hA, 16'h0000, 4'b0000, 0, 1, 0, 4'd0};
        vt[13] = '{4'h1, 16'h0000, 4'b0000, 0, 1, 0, 4'd0};
        vt[14] = '{4'hC, 16'h0000, 4'b0000, 0, 0, 0, 4'd0};
        vt[15] = '{4'hD, 16'h0000, 4'b0000, 1, 0, 0, 4'd0};
        vt[16] = '{4'hD, 16'h0000, 4'b0000, 0, 0, 0, 4'd0};
        vt[17] = '{4'hA, 16'h0000, 4'b0000, 0, 0, 0, 4'd0};
        vt[18] = '{4'h5, 16'h5000, 4'b0001, 0, 0, 0, 4'd0};
        vt[19] = '{4'h6, 16'h5600, 4'b0011, 0, 0, 0, 4'd0};
        vt[20] = '{4'h7, 16'h5670, 4'b0111, 0, 0, 0, 4'd0};
        vt[21] = '{4'h8, 16'h5678, 4'b1111, 0, 0, 0, 4'd0};
        vt[22] = '{4'h9, 16'h5678, 4'b1111, 0, 0, 0, 4'd0};
        vt[23] = '{4'hA, 16'h0000, 4'b0000, 0, 0, 0, 4'd1};
        vt[24] = '{4'hF, 16'h0000, 4'b0000, 0, 0, 0, 4'd1};
        vt[25] = '{4'hB, 16'h0000, 4'b0000, 0, 0, 0, 4'd1};
        vt[26] = '{4'h0, 16'h0000, 4'b0001, 0, 0, 0, 4'd1};
        vt[27] = '{4'h0, 16'h0000, 4'b0011, 0, 0, 0, 4'd1};
        vt[28] = '{4'h0, 16'h0000, 4'b0111, 0, 0, 0, 4'd1};
        vt[29] = '{4'h0, 16'h0000, 4'b1111, 0, 0, 0, 4'd1};
        vt[30] = '{4'hA, 16'h0000, 4'b0000, 0, 0, 0, 4'd2};
        vt[31] = '{4'h9, 16'h9000, 4'b0001, 0, 0, 0, 4'd2};
        vt[32] = '{4'h9, 16'h9900, 4'b0011, 0, 0, 0, 4'd2};
        vt[33] = '{4'h9, 16'h9990, 4'b0111, 0, 0, 0, 4'd2};
        vt[34] = '{4'h9, 16'h9999, 4'b1111, 0, 0, 0, 4'd2};
        vt[35] = '{4'hA, 16'h0000, 4'b0000, 0, 0, 1, 4'd3};

        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        #12;
        chk("reset", mk(16'h0, 4'b0, 0, 0, 0, 4'd0));
        release_reset();

        for (int i = 0; i < 36; i++) begin
            apply(vt[i].key);
            chk($sformatf("vec%0d", i), mk(vt[i].p, vt[i].dv, vt[i].st, vt[i].unl, vt[i].alm, vt[i].fc));
        end

        // Lockout: keys (including D) ignored for 99 cycles, exit on the 100th.
        for (int i = 1; i < 100; i++) begin
            case (i)
                10: apply(4'h1);
                11: apply(4'h2);
                12: apply(4'h3);
                13: apply(4'h4);
                14: apply(4'hA);
                20: apply(4'hD);
                default: idle();
            endcase
            chk($sformatf("lock%0d", i), mk(16'h0, 4'b0, 0, 0, 1, 4'd3));
        end
        apply(4'h7);
        chk("lock_exit", mk(16'h0, 4'b0, 0, 0, 0, 4'd0));
        code(4'h1, 4'h2, 4'h3, 4'h4);
        chk("post_lock_unlock", mk(16'h0, 4'b0, 0, 1, 0, 4'd0));

        // Reset mid-entry.
        apply(4'hC);
        apply(4'h1);
        apply(4'h2);
        chk("mid_entry", mk(16'h1200, 4'b0011, 0, 0, 0, 4'd0));
        pulse_reset();
        chk("rst_mid_entry", mk(16'h0, 4'b0, 0, 0, 0, 4'd0));
        release_reset();

        // Reset mid-lockout.
        code(4'h0, 4'h0, 4'h0, 4'h1);
        code(4'h0, 4'h0, 4'h0, 4'h1);
        code(4'h0, 4'h0, 4'h0, 4'h1);
        chk("relock_alarm", mk(16'h0, 4'b0, 0, 0, 1, 4'd3));
        repeat (5) idle();
        pulse_reset();
        chk("rst_mid_lock", mk(16'h0, 4'b0, 0, 0, 0, 4'd0));
        release_reset();
        idle();
        chk("after_rst_idle", mk(16'h0, 4'b0, 0, 0, 0, 4'd0));
        code(4'h1, 4'h2, 4'h3, 4'h4);
        chk("after_rst_unlock", mk(16'h0, 4'b0, 0, 1, 0, 4'd0));

`ifdef PW_CHANGE_EN
        apply(4'hE);
        chk("setpw_enter", mk(16'h0, 4'b0, 0, 1, 0, 4'd0));
        apply(4'h9); apply(4'h8); apply(4'h7); apply(4'h6);
        chk("setpw_digits", mk(16'h9876, 4'b1111, 0, 1, 0, 4'd0));
        apply(4'hA);
        chk("setpw_store", mk(16'h0, 4'b0, 0, 1, 0, 4'd0));
        apply(4'hC);
        chk("setpw_relock", mk(16'h0, 4'b0, 0, 0, 0, 4'd0));
        code(4'h1, 4'h2, 4'h3, 4'h4);
        chk("old_pw_fails", mk(16'h0, 4'b0, 0, 0, 0, 4'd1));
        code(4'h9, 4'h8, 4'h7, 4'h6);
        chk("new_pw_unlocks", mk(16'h0, 4'b0, 0, 1, 0, 4'd0));
        apply(4'hC);
        apply(4'h1);
        apply(4'h2);
        pulse_reset();
        chk("rst_after_chg", mk(16'h0, 4'b0, 0, 0, 0, 4'd0));
        release_reset();
        code(4'h1, 4'h2, 4'h3, 4'h4);
        chk("default_pw_back", mk(16'h0, 4'b0, 0, 1, 0, 4'd0));
`else
        apply(4'hE);
        chk("chpw_ignored", mk(16'h0, 4'b0, 0, 1, 0, 4'd0));
        apply(4'h9);
        chk("digit_in_unlocked", mk(16'h0, 4'b0, 0, 1, 0, 4'd0));
        apply(4'hC);
        chk("relock", mk(16'h0, 4'b0, 0, 0, 0, 4'd0));
        code(4'h1, 4'h2, 4'h3, 4'h4);
        chk("pw_unchanged", mk(16'h0, 4'b0, 0, 1, 0, 4'd0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
